// File: rtl/cfg_dff_chain.sv
// cfg_dff_chain: configurable register chain with hold, parallel load, serial
// shift and rotate, plus a small fill tracker (EMPTY -> FILLING -> FULL) that
// counts serially received bits and flags done once WIDTH bits have arrived.
// There is no handshake on this block: every control input is sampled on every
// rising clk edge. Priority is reset, then set, then mode.
module cfg_dff_chain #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             scan_in,
   output logic [WIDTH-1:0] q,
   output logic             scan_out,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             done,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [WIDTH-1:0] q_shift;
   logic [WIDTH-1:0] q_rot;

   // A one-bit chain has no upper slice: shift just takes scan_in, rotate is a no-op.
   if (WIDTH == 1) begin : g_w1
      assign q_shift = scan_in;
      assign q_rot   = q;
   end else begin : g_wn
      assign q_shift = {q[WIDTH-2:0], scan_in};
      assign q_rot   = {q[WIDTH-2:0], q[WIDTH-1]};
   end

   // Next data, count and fill state from set and mode (reset handled in the register).
   always_comb begin
      q_nxt     = q;
      cnt_nxt   = bit_cnt;
      state_nxt = state;
      if (set) begin
         q_nxt     = '1;
         cnt_nxt   = '0;
         state_nxt = EMPTY;
      end else begin
         case (mode)
            2'b01: begin
               q_nxt     = d;
               cnt_nxt   = CNT_MAX;
               state_nxt = FULL;
            end
            2'b10: begin
               q_nxt = q_shift;
               // Saturate at WIDTH so a long scan stream never wraps the count.
               if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + 1'b1;
               case (state)
                  EMPTY:   state_nxt = (WIDTH == 1) ? FULL : FILLING;
                  FILLING: if (bit_cnt == CNT_MAX - 1'b1) state_nxt = FULL;
                  FULL:    state_nxt = FULL;
                  default: state_nxt = EMPTY;
               endcase
            end
            2'b11: q_nxt = q_rot;
            default: ;
         endcase
      end
   end

   // State register; done is registered from the next state so it tracks FULL exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         q       <= '0;
         bit_cnt <= '0;
         state   <= EMPTY;
         done    <= 1'b0;
      end else begin
         q       <= q_nxt;
         bit_cnt <= cnt_nxt;
         state   <= state_nxt;
         done    <= (state_nxt == FULL);
      end
   end

   assign scan_out  = q[WIDTH-1];
   assign state_dbg = state;

endmodule

// File: tb/tb_cfg_dff_chain.sv
// Directed bench for cfg_dff_chain: an 8-bit instance covers load, shift, rotate,
// saturation and reset/set priority; a 1-bit instance covers the degenerate width.
module tb_cfg_dff_chain;

   localparam logic [1:0] S_EMPTY   = 2'd0;
   localparam logic [1:0] S_FILLING = 2'd1;
   localparam logic [1:0] S_FULL    = 2'd2;

   logic       clk = 1'b0;
   // 8-bit instance
   logic       reset8, set8, scan_in8;
   logic [1:0] mode8;
   logic [7:0] d8, q8;
   logic       scan_out8, done8;
   logic [3:0] cnt8;
   logic [1:0] st8;
   // 1-bit instance
   logic       reset1, set1, scan_in1;
   logic [1:0] mode1;
   logic [0:0] d1, q1;
   logic       scan_out1, done1;
   logic [0:0] cnt1;
   logic [1:0] st1;

   int errors = 0;
   int checks = 0;

   // clock
   always #5 clk = ~clk;

   cfg_dff_chain #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset8), .set(set8), .mode(mode8), .d(d8),
      .scan_in(scan_in8), .q(q8), .scan_out(scan_out8), .bit_cnt(cnt8),
      .done(done8), .state_dbg(st8)
   );

   cfg_dff_chain #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset1), .set(set1), .mode(mode1), .d(d1),
      .scan_in(scan_in1), .q(q1), .scan_out(scan_out1), .bit_cnt(cnt1),
      .done(done1), .state_dbg(st1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one edge; outputs are stable 1 time unit later, inputs change there too
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic shift8(input logic b);
      mode8 = 2'b10; scan_in8 = b;
      step();
   endtask

   initial begin
      logic [7:0]  pat8;
      logic [11:0] pat12;
      reset8 = 1'b1; set8 = 1'b0; mode8 = 2'b00; d8 = 8'h00; scan_in8 = 1'b0;
      reset1 = 1'b1; set1 = 1'b0; mode1 = 2'b00; d1 = 1'b0;  scan_in1 = 1'b0;
      #2;

      // reset state
      step();
      check("rst_q", q8, 8'h00);
      check("rst_cnt", cnt8, 4'd0);
      check("rst_done", done8, 1'b0);
      check("rst_state", st8, S_EMPTY);
      check("rst_scan_out", scan_out8, 1'b0);
      reset8 = 1'b0;

      // serial fill 1,0,1,1,0,0,1,0
      pat8 = 8'b1011_0010;
      for (int i = 7; i >= 1; i--) shift8(pat8[i]);
      check("fill7_done", done8, 1'b0);
      check("fill7_cnt", cnt8, 4'd7);
      check("fill7_state", st8, S_FILLING);
      shift8(pat8[0]);
      check("fill8_q", q8, 8'hB2);
      check("fill8_cnt", cnt8, 4'd8);
      check("fill8_done", done8, 1'b1);
      check("fill8_scan_out", scan_out8, 1'b1);

      // parallel load then rotate x3
      mode8 = 2'b01; d8 = 8'hA5;
      step();
      check("load_q", q8, 8'hA5);
      check("load_done", done8, 1'b1);
      check("load_cnt", cnt8, 4'd8);
      mode8 = 2'b11;
      step();
      check("rot1_q", q8, 8'h4B);
      step(); step();
      check("rot3_q", q8, 8'h2D);
      check("rot3_done", done8, 1'b1);
      check("rot3_cnt", cnt8, 4'd8);
      mode8 = 2'b00;
      step(); step();
      check("hold_q", q8, 8'h2D);
      check("hold_state", st8, S_FULL);

      // partial fill discarded by reset, then refill
      reset8 = 1'b1; step(); reset8 = 1'b0;
      for (int i = 0; i < 5; i++) shift8(1'b1);
      check("part_cnt", cnt8, 4'd5);
      check("part_q", q8, 8'h1F);
      reset8 = 1'b1; mode8 = 2'b10; step(); reset8 = 1'b0;
      check("midrst_q", q8, 8'h00);
      check("midrst_cnt", cnt8, 4'd0);
      check("midrst_done", done8, 1'b0);
      for (int i = 0; i < 7; i++) shift8(1'b0);
      check("refill7_done", done8, 1'b0);
      shift8(1'b1);
      check("refill8_done", done8, 1'b1);
      check("refill8_q", q8, 8'h01);

      // reset beats set beats mode
      reset8 = 1'b1; set8 = 1'b1; mode8 = 2'b01; d8 = 8'hFF;
      step();
      check("rst_set_q", q8, 8'h00);
      check("rst_set_state", st8, S_EMPTY);
      reset8 = 1'b0; d8 = 8'h3C;
      step();
      check("set_q", q8, 8'hFF);
      check("set_cnt", cnt8, 4'd0);
      check("set_done", done8, 1'b0);
      check("set_state", st8, S_EMPTY);
      set8 = 1'b0; mode8 = 2'b00;
      step();
      check("set_hold_q", q8, 8'hFF);

      // 12 shifts: count saturates, q keeps the last 8 bits
      pat12 = 12'b1100_0101_1010;
      for (int i = 11; i >= 0; i--) shift8(pat12[i]);
      check("sat_cnt", cnt8, 4'd8);
      check("sat_done", done8, 1'b1);
      check("sat_q", q8, 8'h5A);
      check("sat_state", st8, S_FULL);
      mode8 = 2'b00;

      // one-bit chain
      reset1 = 1'b0; mode1 = 2'b10; scan_in1 = 1'b1;
      step();
      check("w1_q", q1, 1'b1);
      check("w1_done", done1, 1'b1);
      check("w1_cnt", cnt1, 1'b1);
      check("w1_scan_out", scan_out1, 1'b1);
      scan_in1 = 1'b0;
      step();
      check("w1_q2", q1, 1'b0);
      check("w1_cnt_sat", cnt1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cfg_dff_chain.md
CFG_DFF_CHAIN -- requirements
Module: cfg_dff_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register bit count; legal range is 1..64.
REQ-002 The block SHALL have derived parameter CNT_W, equal to clog2(WIDTH+1), giving the counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port set, input, 1 bit: synchronous active-high preset of all bits to 1.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 hold, 01 parallel load, 10 shift, 11 rotate.
REQ-007 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-008 The block SHALL have port scan_in, input, 1 bit: serial data into bit 0.
REQ-009 The block SHALL have port q, output, WIDTH bits: registered contents.
REQ-010 The block SHALL have port scan_out, output, 1 bit: combinational copy of q[WIDTH-1].
REQ-011 The block SHALL have port bit_cnt, output, CNT_W bits: registered count of serial bits received, saturating at WIDTH.
REQ-012 The block SHALL have port done, output, 1 bit: registered; high while the fill state machine is in FULL.

Function
REQ-013 Priority per rising clk edge SHALL be: reset, then set, then mode.
REQ-014 On reset: q=0, bit_cnt=0, state=EMPTY, done=0.
REQ-015 On set (reset low): q all ones, bit_cnt=0, state=EMPTY, done=0.
REQ-016 On mode 00: q, bit_cnt and state hold.
REQ-017 On mode 01: q<=d, bit_cnt<=WIDTH, state<=FULL, in one cycle.
REQ-018 On mode 10: q<={q[WIDTH-2:0],scan_in}; for WIDTH=1, q<=scan_in.
REQ-019 In mode 10, bit_cnt SHALL increment by 1 and saturate at WIDTH; it never wraps to 0.
REQ-020 On mode 11: q<={q[WIDTH-2:0],q[WIDTH-1]}; bit_cnt and state hold.
REQ-021 FSM states SHALL be EMPTY, FILLING and FULL.
REQ-022 In EMPTY, mode 10 SHALL move to FILLING, or to FULL when WIDTH=1.
REQ-023 In FILLING, mode 10 with bit_cnt==WIDTH-1 SHALL move to FULL; other mode 10 cycles stay in FILLING.
REQ-024 In FULL, further shifts SHALL stay in FULL with bit_cnt held at WIDTH.
REQ-025 Only reset or set SHALL leave FULL.
REQ-026 Mode 01 from any state SHALL go to FULL.
REQ-027 done SHALL rise in the cycle after the WIDTH-th shift edge; latency from the last scan bit to done is 1 clk.
REQ-028 scan_out SHALL reflect q[WIDTH-1] with no added latency.
REQ-029 Chaining scan_out to a downstream scan_in SHALL give exactly 1-cycle delay per bit.
REQ-030 When reset and set are both asserted, reset SHALL win and q=0.
REQ-031 When set and mode are asserted together, set SHALL win and mode is ignored that cycle.
REQ-032 Reset or set asserted mid-fill SHALL discard partial contents and count the same cycle, then restart from EMPTY.
REQ-033 Undefined mode values SHALL NOT exist: all 4 encodings are defined.

Reset
REQ-034 Reset SHALL be sampled only on the rising clk edge; no asynchronous path to any flop.
REQ-035 After reset deassertion, the first active mode SHALL take effect on the next edge.
REQ-036 The block SHALL have no reset-release latency beyond that edge.
REQ-037 All outputs SHALL be defined (0) from the first clk edge with reset high.

Verification
REQ-038 WIDTH=8: reset 1 cycle, then mode=10 with scan_in 1,0,1,1,0,0,1,0 -> after 8 edges q=8'b1011_0010, bit_cnt=8, done=1 one cycle after the last shift, scan_out=1.
REQ-039 WIDTH=8: mode=01, d=8'hA5 -> next edge q=8'hA5, done=1, bit_cnt=8; then mode=11 x3 -> q=8'h2D, done stays 1.
REQ-040 WIDTH=8: shift 5 bits, then assert reset -> q=0, bit_cnt=0, done=0; 8 fresh shifts are needed to re-reach FULL.
REQ-041 WIDTH=8: reset=1, set=1, mode=01, d=8'hFF in the same cycle -> q=0, state=EMPTY; set=1 alone -> q=8'hFF, bit_cnt=0, done=0.
REQ-042 WIDTH=8: 12 consecutive shifts -> bit_cnt saturates at 8 (no wrap), done stays 1, q holds the last 8 scan bits.
REQ-043 WIDTH=1: single shift of 1 -> q=1, done=1 next cycle, bit_cnt=1, scan_out=1.
